// File: rtl/fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fixed_pkg
//  Brief   : Shared map-coordinate types and octant flags for the ray pipeline.
//  Revision: 1.0 - initial release
// ============================================================================
package fixed_pkg;

    localparam int FIXED_COORD_W = 16;
    localparam int FIXED_LEN_W   = 16;

    typedef logic signed [FIXED_COORD_W-1:0] coord_t;
    typedef logic        [FIXED_LEN_W-1:0]   delta_t;

    typedef struct packed {
        logic flip_y;
        logic flip_x;
        logic flip_identity;
    } octant_flags_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } walk_state_t;

endpackage
`default_nettype wire

// File: rtl/octant_unmap.sv
`default_nettype none
// ============================================================================
//  Module  : octant_unmap
//  Brief   : Maps a first-octant offset (u,v) back to a signed map offset (a,b).
//  Revision: 1.0 - initial release
// ============================================================================
module octant_unmap
    import fixed_pkg::*;
#(
    parameter int COORD_W = FIXED_COORD_W,
    parameter int LEN_W   = FIXED_LEN_W
) (
    input  logic [LEN_W-1:0]          u,
    input  logic [LEN_W-1:0]          v,
    input  octant_flags_t             flags,
    output logic signed [COORD_W-1:0] a,
    output logic signed [COORD_W-1:0] b
);

    logic [COORD_W-1:0] w_u_ext;
    logic [COORD_W-1:0] w_v_ext;
    logic [COORD_W-1:0] w_a_pre;
    logic [COORD_W-1:0] w_b_pre;

    assign w_u_ext = COORD_W'(u);
    assign w_v_ext = COORD_W'(v);

    // Undo the reduction in reverse order: axis swap first, then the sign flips.
    assign w_a_pre = flags.flip_identity ? w_v_ext : w_u_ext;
    assign w_b_pre = flags.flip_identity ? w_u_ext : w_v_ext;

    assign a = flags.flip_x ? $signed(-w_a_pre) : $signed(w_a_pre);
    assign b = flags.flip_y ? $signed(-w_b_pre) : $signed(w_b_pre);

endmodule
`default_nettype wire

// File: rtl/bresenham_walker.sv
`default_nettype none
// ============================================================================
//  Module  : bresenham_walker
//  Brief   : One-cell-per-cycle Bresenham walker with octant unfolding.
//            Define BRESENHAM_SKIP_ORIGIN_EN to suppress the start cell.
//  Revision: 1.0 - initial release
// ============================================================================
module bresenham_walker
    import fixed_pkg::*;
#(
    parameter int COORD_W = FIXED_COORD_W,
    parameter int LEN_W   = FIXED_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [LEN_W-1:0]   dx,
    input  logic [LEN_W-1:0]   dy,
    input  logic               flip_y,
    input  logic               flip_x,
    input  logic               flip_identity,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] cell_x,
    output logic [COORD_W-1:0] cell_y,
    output logic               cell_last,
    output logic               busy
);

    localparam int E_W = LEN_W + 2;

`ifdef BRESENHAM_SKIP_ORIGIN_EN
    localparam logic c_SKIP_ORIGIN = 1'b1;
`else
    localparam logic c_SKIP_ORIGIN = 1'b0;
`endif

    walk_state_t          r_state;
    walk_state_t          w_state_next;
    logic [COORD_W-1:0]   r_x0;
    logic [COORD_W-1:0]   r_y0;
    octant_flags_t        r_flags;
    logic [LEN_W-1:0]     r_dx;
    logic [LEN_W-1:0]     r_dy;
    logic [LEN_W-1:0]     r_u;
    logic [LEN_W-1:0]     r_v;
    logic signed [E_W-1:0] r_e;
    logic [COORD_W-1:0]   r_cell_x;
    logic [COORD_W-1:0]   r_cell_y;
    logic                 r_cell_last;

    logic                 w_load;
    logic                 w_enter;
    logic                 w_take;
    logic                 w_adv;
    logic                 w_done;
    logic                 w_do_step;
    logic                 w_e_pos;
    logic [LEN_W-1:0]     w_dy_in_eff;
    octant_flags_t        w_in_flags;
    octant_flags_t        w_sel_flags;
    logic [COORD_W-1:0]   w_sel_x0;
    logic [COORD_W-1:0]   w_sel_y0;
    logic [LEN_W-1:0]     w_sel_dx;
    logic [LEN_W-1:0]     w_sel_dy;
    logic [LEN_W-1:0]     w_sel_u;
    logic [LEN_W-1:0]     w_sel_v;
    logic signed [E_W-1:0] w_sel_e;
    logic signed [E_W-1:0] w_two_dy;
    logic signed [E_W-1:0] w_two_dx;
    logic signed [E_W-1:0] w_step_e;
    logic [LEN_W-1:0]     w_new_u;
    logic [LEN_W-1:0]     w_new_v;
    logic signed [E_W-1:0] w_new_e;
    logic                 w_new_last;
    logic signed [COORD_W-1:0] w_a;
    logic signed [COORD_W-1:0] w_b;

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (r_state == ST_RUN);
    assign cell_x    = r_cell_x;
    assign cell_y    = r_cell_y;
    assign cell_last = r_cell_last;

    assign w_load  = in_valid && in_ready;
    // With the origin suppressed a zero-length segment has nothing to emit.
    assign w_enter = w_load && !(c_SKIP_ORIGIN && (dx == '0));
    assign w_take  = out_valid && out_ready;
    assign w_adv   = w_take && !r_cell_last;
    assign w_done  = w_take && r_cell_last;

    assign w_dy_in_eff = (dy > dx) ? dx : dy;
    assign w_in_flags  = '{flip_y: flip_y, flip_x: flip_x, flip_identity: flip_identity};

    // A fresh segment and an advancing one share a single step/unmap datapath.
    assign w_sel_flags = w_load ? w_in_flags  : r_flags;
    assign w_sel_x0    = w_load ? x0          : r_x0;
    assign w_sel_y0    = w_load ? y0          : r_y0;
    assign w_sel_dx    = w_load ? dx          : r_dx;
    assign w_sel_dy    = w_load ? w_dy_in_eff : r_dy;
    assign w_sel_u     = w_load ? '0          : r_u;
    assign w_sel_v     = w_load ? '0          : r_v;
    assign w_sel_e     = w_load ? ($signed({1'b0, w_dy_in_eff, 1'b0}) - $signed({2'b00, dx}))
                                : r_e;

    assign w_two_dy  = $signed({1'b0, w_sel_dy, 1'b0});
    assign w_two_dx  = $signed({1'b0, w_sel_dx, 1'b0});
    assign w_e_pos   = !w_sel_e[E_W-1] && (w_sel_e != '0);
    assign w_step_e  = w_e_pos ? (w_sel_e + w_two_dy - w_two_dx) : (w_sel_e + w_two_dy);
    assign w_do_step = w_adv || (w_load && c_SKIP_ORIGIN);

    assign w_new_u    = w_do_step ? (w_sel_u + LEN_W'(1)) : w_sel_u;
    assign w_new_v    = (w_do_step && w_e_pos) ? (w_sel_v + LEN_W'(1)) : w_sel_v;
    assign w_new_e    = w_do_step ? w_step_e : w_sel_e;
    assign w_new_last = (w_new_u == w_sel_dx);

    octant_unmap #(
        .COORD_W (COORD_W),
        .LEN_W   (LEN_W)
    ) u_unmap (
        .u     (w_new_u),
        .v     (w_new_v),
        .flags (w_sel_flags),
        .a     (w_a),
        .b     (w_b)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_enter) w_state_next = ST_RUN;
            ST_RUN:  if (w_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_flags     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_u         <= '0;
            r_v         <= '0;
            r_e         <= '0;
            r_cell_x    <= '0;
            r_cell_y    <= '0;
            r_cell_last <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load || w_adv) begin
                r_x0        <= w_sel_x0;
                r_y0        <= w_sel_y0;
                r_flags     <= w_sel_flags;
                r_dx        <= w_sel_dx;
                r_dy        <= w_sel_dy;
                r_u         <= w_new_u;
                r_v         <= w_new_v;
                r_e         <= w_new_e;
                r_cell_x    <= w_sel_x0 + w_a;
                r_cell_y    <= w_sel_y0 + w_b;
                r_cell_last <= w_new_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bresenham_walker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bresenham_walker
//  Brief   : Self-checking bench for bresenham_walker against a closed-form
//            line model (v = dy*u/dx rounded half-down).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_bresenham_walker;

`ifdef BRESENHAM_SKIP_ORIGIN_EN
    localparam longint START_U = 1;
`else
    localparam longint START_U = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x0, y0, dx, dy;
    logic        flip_y, flip_x, flip_identity;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] cell_x, cell_y;
    logic        cell_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_x[$];
    logic [15:0] exp_y[$];
    logic        exp_l[$];

    bresenham_walker #(.COORD_W(16), .LEN_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .x0            (x0),
        .y0            (y0),
        .dx            (dx),
        .dy            (dy),
        .flip_y        (flip_y),
        .flip_x        (flip_x),
        .flip_identity (flip_identity),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .cell_x        (cell_x),
        .cell_y        (cell_y),
        .cell_last     (cell_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void build_expect(input logic [15:0] sx, sy, sdx, sdy,
                                         input logic fy, fx, fi);
        longint ldx = longint'(sdx);
        longint ldy = (sdy > sdx) ? longint'(sdx) : longint'(sdy);
        exp_x.delete();
        exp_y.delete();
        exp_l.delete();
        for (longint u = START_U; u <= ldx; u++) begin
            longint v, a, b;
            v = (ldx == 0) ? 0 : (2 * ldy * u + ldx - 1) / (2 * ldx);
            a = fi ? v : u;
            b = fi ? u : v;
            if (fx) a = -a;
            if (fy) b = -b;
            exp_x.push_back(16'(longint'(sx) + a));
            exp_y.push_back(16'(longint'(sy) + b));
            exp_l.push_back(u == ldx);
        end
    endfunction

    task automatic send(input logic [15:0] sx, sy, sdx, sdy, input logic fy, fx, fi,
                        input string tag);
        int w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before act=%b exp=1", tag, in_ready);
        end
        x0 = sx; y0 = sy; dx = sdx; dy = sdy;
        flip_y = fy; flip_x = fx; flip_identity = fi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: toggle ready, 2: random ready
    task automatic walk(input logic [15:0] sx, sy, sdx, sdy, input logic fy, fx, fi,
                        input int mode, input string tag);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        build_expect(sx, sy, sdx, sdy, fy, fx, fi);
        send(sx, sy, sdx, sdy, fy, fx, fi, tag);
        if (exp_x.size() == 0) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s empty_segment act=valid%b/ready%b exp=valid0/ready1",
                         tag, out_valid, in_ready);
            end
            return;
        end
        while (idx < exp_x.size() && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid cyc=%0d act=%b exp=1", tag, cyc, out_valid);
            end else begin
                checks++;
                if ({cell_x, cell_y, cell_last} !== {exp_x[idx], exp_y[idx], exp_l[idx]}) begin
                    errors++;
                    $display("FAIL %s cell[%0d] act=(%h,%h,%b) exp=(%h,%h,%b)", tag, idx,
                             cell_x, cell_y, cell_last, exp_x[idx], exp_y[idx], exp_l[idx]);
                end
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s in_ready_run act=%b/%b exp=0/1", tag, in_ready, busy);
                end
                if (rdy) idx++;
            end
            out_ready = rdy;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (idx != exp_x.size()) begin
            errors++;
            $display("FAIL %s cell_count act=%0d exp=%0d", tag, idx, exp_x.size());
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end_state act=valid%b/ready%b/busy%b exp=valid0/ready1/busy0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x0 = '0; y0 = '0; dx = '0; dy = '0;
        flip_y = 1'b0; flip_x = 1'b0; flip_identity = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ready, out_valid, cell_x, cell_y, cell_last, busy} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values act=rdy%b val%b (%h,%h) last%b busy%b exp=rdy1 val0 (0000,0000) last0 busy0",
                     in_ready, out_valid, cell_x, cell_y, cell_last, busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        walk(16'd10, 16'd20, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0, 0, "basic");
        walk(16'd5, 16'd5, 16'd2, 16'd1, 1'b0, 1'b1, 1'b1, 0, "swap_fx");
        walk(16'd5, 16'd5, 16'd2, 16'd1, 1'b1, 1'b1, 1'b1, 0, "swap_fx_fy");
    endtask

    task automatic test_stall();
        walk(16'd100, 16'd200, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0, 1, "stall_diag");
        walk(16'd7, 16'd9, 16'd6, 16'd4, 1'b1, 1'b0, 1'b1, 2, "stall_rand");
    endtask

    task automatic test_dx_zero();
        walk(16'h1234, 16'h8765, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 0, "dx_zero");
    endtask

    task automatic test_wrap_clamp();
        walk(16'hFFFF, 16'h0000, 16'd2, 16'd0, 1'b0, 1'b0, 1'b0, 0, "wrap");
        walk(16'h0000, 16'h0000, 16'd2, 16'd5, 1'b0, 1'b0, 1'b0, 0, "clamp");
    endtask

    task automatic test_back_to_back();
        walk(16'd1, 16'd1, 16'd3, 16'd1, 1'b0, 1'b1, 1'b0, 0, "b2b_a");
        walk(16'd50, 16'd60, 16'd5, 16'd2, 1'b1, 1'b0, 1'b1, 0, "b2b_b");
    endtask

    task automatic test_reset_midwalk();
        build_expect(16'd10, 16'd20, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0);
        send(16'd10, 16'd20, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0, "midrst");
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, cell_x, cell_y} !== {1'b1, exp_x[2], exp_y[2]}) begin
            errors++;
            $display("FAIL midrst third_cell act=%b(%h,%h) exp=1(%h,%h)",
                     out_valid, cell_x, cell_y, exp_x[2], exp_y[2]);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({out_valid, in_ready, cell_x, cell_y, cell_last, busy} !== {1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst after_reset act=val%b rdy%b (%h,%h) last%b busy%b exp=val0 rdy1 (0000,0000) last0 busy0",
                     out_valid, in_ready, cell_x, cell_y, cell_last, busy);
        end
        rst_n = 1'b1;
        tick();
        walk(16'd3, 16'hFFFE, 16'd5, 16'd3, 1'b1, 1'b1, 1'b0, 0, "post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] rdx, rdy;
            rdx = 16'($urandom_range(0, 40));
            rdy = 16'($urandom_range(0, 32'(rdx) + 3));
            walk(16'($urandom), 16'($urandom), rdx, rdy,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_dx_zero();
        test_wrap_clamp();
        test_back_to_back();
        test_reset_midwalk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
